// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared memory-op encodings, arbiter state codes and the
//               latched transaction record used by mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  localparam logic [2:0] LNONE = 3'd0;
  localparam logic [2:0] LB    = 3'd1;
  localparam logic [2:0] LH    = 3'd2;
  localparam logic [2:0] LW    = 3'd3;
  localparam logic [2:0] LBU   = 3'd4;
  localparam logic [2:0] LHU   = 3'd5;

  localparam logic [1:0] SNONE = 2'd0;
  localparam logic [1:0] SB    = 2'd1;
  localparam logic [1:0] SH    = 2'd2;
  localparam logic [1:0] SW    = 2'd3;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_BUSY = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  read_op;
    logic [1:0]  write_op;
    logic [31:0] wdata;
  } mem_txn_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational winner select between two requesters.
//               MEM_ARB_ROUND_ROBIN_EN adds the last-grant pointer input.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick (
  input  logic req0,
  input  logic req1,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic last_gnt,
`endif
  output logic winner
);

  always_comb begin
    winner = 1'b0;
    if (req1 && !req0) begin
      winner = 1'b1;
    end else if (req0 && req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      winner = ~last_gnt;
`else
      winner = 1'b0;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Serialises whole memory transactions from two masters onto
//               one memory port. MEM_ARB_ROUND_ROBIN_EN enables fair arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [2:0]  m0_read_op,
  input  logic [1:0]  m0_write_op,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [2:0]  m1_read_op,
  input  logic [1:0]  m1_write_op,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_read_op,
  output logic [1:0]  mem_write_op,
  output logic [31:0] mem_wdata,
  output logic        mem_init,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  logic [0:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       first_q, first_d;
  mem_txn_t   txn_q,   txn_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic       last_q,  last_d;
`endif

  mem_txn_t   m0_txn, m1_txn;
  logic       winner;
  logic       is_read, is_write, txn_done;

  assign m0_txn = '{addr: m0_addr, read_op: m0_read_op, write_op: m0_write_op, wdata: m0_wdata};
  assign m1_txn = '{addr: m1_addr, read_op: m1_read_op, write_op: m1_write_op, wdata: m1_wdata};

  // A load takes precedence over a store encoded in the same request.
  assign is_read  = (txn_q.read_op != LNONE);
  assign is_write = !is_read && (txn_q.write_op != SNONE);
  assign txn_done = is_read ? mem_ready : 1'b1;

  mem_arb_pick u_pick (
    .req0     (m0_req),
    .req1     (m1_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_gnt (last_q),
`endif
    .winner   (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= 1'b0;
      first_q <= 1'b0;
      txn_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      first_q <= first_d;
      txn_q   <= txn_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  // The request is captured at grant so a mid-transaction req drop is harmless.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    first_d = 1'b0;
    txn_d   = txn_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (m0_req || m1_req) begin
          state_d = ARB_BUSY;
          owner_d = winner;
          first_d = 1'b1;
          txn_d   = winner ? m1_txn : m0_txn;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d  = winner;
`endif
        end
      end
      default: begin
        if (txn_done) begin
          state_d = ARB_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    m0_done      = 1'b0;
    m1_done      = 1'b0;
    m0_rdata     = '0;
    m1_rdata     = '0;
    mem_addr     = '0;
    mem_read_op  = LNONE;
    mem_write_op = SNONE;
    mem_wdata    = '0;
    mem_init     = 1'b0;
    if (state_q == ARB_BUSY) begin
      m0_gnt  = ~owner_q;
      m1_gnt  = owner_q;
      m0_done = txn_done & ~owner_q;
      m1_done = txn_done & owner_q;
      if (owner_q) begin
        m1_rdata = mem_rdata;
      end else begin
        m0_rdata = mem_rdata;
      end
      if (is_read) begin
        mem_addr    = txn_q.addr;
        mem_read_op = txn_q.read_op;
        mem_init    = first_q;
      end else if (is_write) begin
        mem_addr     = txn_q.addr;
        mem_write_op = txn_q.write_op;
        mem_wdata    = txn_q.wdata;
      end
    end
  end

endmodule

`default_nettype wire
